vga_timing_gen: RTL and testbench

Parametrised raster timing generator. It supersedes the fixed 640x480 VGA controller with configurable horizontal/vertical geometry, sync polarity and pixel-clock division, and adds frame, line, vblank and programmable raster-line event pulses. It drives the GPU coordinates, the display-enable mux and the frame-sync controller, which keys its copy window on `vblank_start`.

---
 rtl/vga_timing_gen.sv | 127 ++++++++++++
 tb/tb_vga_timing_gen.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing generator.
// A clock divider produces the pixel advance; hpos/vpos walk the full raster
// (active + porches + sync). Every output is a register computed from the
// coordinate value being loaded, so syncs, display_on and the event pulses
// are aligned with hpos/vpos in the same cycle. Event pulses are one system
// clock wide and only ever occur in the pixel_en cycle.
module vga_timing_gen #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter bit H_POL       = 1'b0,
  parameter bit V_POL       = 1'b0,
  parameter int CLK_DIV     = 1,
  parameter int COORD_WIDTH = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [COORD_WIDTH-1:0] raster_line,
  output logic [COORD_WIDTH-1:0] hpos,
  output logic [COORD_WIDTH-1:0] vpos,
  output logic                   display_on,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   pixel_en,
  output logic                   line_start,
  output logic                   frame_start,
  output logic                   vblank_start,
  output logic                   raster_hit
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0]       DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [COORD_WIDTH-1:0] H_LAST     = COORD_WIDTH'(H_TOTAL - 1);
  localparam logic [COORD_WIDTH-1:0] V_LAST     = COORD_WIDTH'(V_TOTAL - 1);
  localparam logic [COORD_WIDTH-1:0] H_ACT_C    = COORD_WIDTH'(H_ACTIVE);
  localparam logic [COORD_WIDTH-1:0] V_ACT_C    = COORD_WIDTH'(V_ACTIVE);
  localparam logic [COORD_WIDTH-1:0] HS_START_C = COORD_WIDTH'(HS_START);
  localparam logic [COORD_WIDTH-1:0] HS_END_C   = COORD_WIDTH'(HS_END);
  localparam logic [COORD_WIDTH-1:0] VS_START_C = COORD_WIDTH'(VS_START);
  localparam logic [COORD_WIDTH-1:0] VS_END_C   = COORD_WIDTH'(VS_END);

  logic [DIV_W-1:0]       div;
  logic                   advance;
  logic                   h_wrap;
  logic [COORD_WIDTH-1:0] h_next;
  logic [COORD_WIDTH-1:0] v_next;
  logic                   disp_next;
  logic                   hsync_next;
  logic                   vsync_next;
  logic                   line_next;

  // The coordinates step on the last clock of each divider period.
  assign advance = (div == DIV_LAST);

  // Next raster position and the levels/events that belong to it.
  always_comb begin
    h_wrap     = (hpos == H_LAST);
    h_next     = h_wrap ? '0 : hpos + 1'b1;
    v_next     = vpos;
    if (h_wrap) begin
      v_next = (vpos == V_LAST) ? '0 : vpos + 1'b1;
    end
    disp_next  = (h_next < H_ACT_C) && (v_next < V_ACT_C);
    hsync_next = ((h_next >= HS_START_C) && (h_next < HS_END_C)) ? H_POL : ~H_POL;
    // v_next only moves on an h wrap, so vsync is line-granular by construction.
    vsync_next = ((v_next >= VS_START_C) && (v_next < VS_END_C)) ? V_POL : ~V_POL;
    line_next  = (h_next == '0);
  end

  // Pixel clock divider: counts 0..CLK_DIV-1 and wraps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div <= '0;
    end else if (advance) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  // Coordinate counters and registered outputs; pulses clear outside pixel_en.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hpos         <= H_LAST;
      vpos         <= V_LAST;
      display_on   <= 1'b0;
      hsync        <= ~H_POL;
      vsync        <= ~V_POL;
      pixel_en     <= 1'b0;
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
      vblank_start <= 1'b0;
      raster_hit   <= 1'b0;
    end else begin
      pixel_en     <= advance;
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
      vblank_start <= 1'b0;
      raster_hit   <= 1'b0;
      if (advance) begin
        hpos         <= h_next;
        vpos         <= v_next;
        display_on   <= disp_next;
        hsync        <= hsync_next;
        vsync        <= vsync_next;
        line_start   <= line_next;
        frame_start  <= line_next && (v_next == '0);
        vblank_start <= line_next && (v_next == V_ACT_C);
        // raster_line is sampled here, at the line start; out-of-range never matches.
        raster_hit   <= line_next && (v_next == raster_line);
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: three generator instances (small active-low, small
// active-high with divide-by-3, default 640x480) checked every cycle against
// a position-from-time reference model, plus literal expectations.
module tb_vga_timing_gen;

  logic       clk;
  logic       reset;
  logic [9:0] raster_line;

  logic [9:0] a_hpos, a_vpos, b_hpos, b_vpos, c_hpos, c_vpos;
  logic a_disp, a_hs, a_vs, a_pen, a_ls, a_fs, a_vbs, a_rh;
  logic b_disp, b_hs, b_vs, b_pen, b_ls, b_fs, b_vbs, b_rh;
  logic c_disp, c_hs, c_vs, c_pen, c_ls, c_fs, c_vbs, c_rh;

  // {hpos, vpos, display_on, hsync, vsync, pixel_en, line_start, frame_start, vblank_start, raster_hit}
  logic [27:0] got [3];
  assign got[0] = {a_hpos, a_vpos, a_disp, a_hs, a_vs, a_pen, a_ls, a_fs, a_vbs, a_rh};
  assign got[1] = {b_hpos, b_vpos, b_disp, b_hs, b_vs, b_pen, b_ls, b_fs, b_vbs, b_rh};
  assign got[2] = {c_hpos, c_vpos, c_disp, c_hs, c_vs, c_pen, c_ls, c_fs, c_vbs, c_rh};

  int n_checks = 0;
  int n_fail   = 0;
  int t        = 0;
  int rl_s     = 0;
  bit phase_fixed = 0;
  bit phase_ras   = 0;
  int cnt [3][8];
  int fs_t [3][2];
  int ls_t [3][2];
  int ras_hits [3];

  vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                   .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)) u_a (
    .clk(clk), .reset(reset), .raster_line(raster_line),
    .hpos(a_hpos), .vpos(a_vpos), .display_on(a_disp), .hsync(a_hs), .vsync(a_vs),
    .pixel_en(a_pen), .line_start(a_ls), .frame_start(a_fs), .vblank_start(a_vbs),
    .raster_hit(a_rh));

  vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                   .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
                   .H_POL(1'b1), .V_POL(1'b1), .CLK_DIV(3)) u_b (
    .clk(clk), .reset(reset), .raster_line(raster_line),
    .hpos(b_hpos), .vpos(b_vpos), .display_on(b_disp), .hsync(b_hs), .vsync(b_vs),
    .pixel_en(b_pen), .line_start(b_ls), .frame_start(b_fs), .vblank_start(b_vbs),
    .raster_hit(b_rh));

  vga_timing_gen u_c (
    .clk(clk), .reset(reset), .raster_line(raster_line),
    .hpos(c_hpos), .vpos(c_vpos), .display_on(c_disp), .hsync(c_hs), .vsync(c_vs),
    .pixel_en(c_pen), .line_start(c_ls), .frame_start(c_fs), .vblank_start(c_vbs),
    .raster_hit(c_rh));

  // Clock: 10 time-unit period, rising edges at 5, 15, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: t = clocks since reset release; the pixel index is t/CLK_DIV
  // and the raster position is that index laid out row-major over the frame.
  function automatic logic [27:0] model(input int k, input int tt, input int rl);
    int ha, hfp, hs, hbp, va, vfp, vs, vbp, cd, ht, vt, p, lin, h, v;
    bit hp, vp;
    logic disp, hsy, vsy, pen, ls, fs, vbs, rh;
    if (k == 2) begin
      ha = 640; hfp = 16; hs = 96; hbp = 48; va = 480; vfp = 10; vs = 2; vbp = 33;
      cd = 1; hp = 0; vp = 0;
    end else begin
      ha = 8; hfp = 2; hs = 3; hbp = 2; va = 6; vfp = 1; vs = 2; vbp = 1;
      cd = (k == 1) ? 3 : 1; hp = (k == 1); vp = (k == 1);
    end
    ht = ha + hfp + hs + hbp;
    vt = va + vfp + vs + vbp;
    p  = tt / cd;
    if (p == 0) begin
      h = ht - 1; v = vt - 1; disp = 0; hsy = ~hp; vsy = ~vp;
    end else begin
      lin  = (p - 1) % (ht * vt);
      h    = lin % ht;
      v    = lin / ht;
      disp = (h < ha) && (v < va);
      hsy  = (h >= ha + hfp && h < ha + hfp + hs) ? hp : ~hp;
      vsy  = (v >= va + vfp && v < va + vfp + vs) ? vp : ~vp;
    end
    pen = (tt != 0) && (tt % cd == 0);
    ls  = pen && (h == 0);
    fs  = ls && (v == 0);
    vbs = ls && (v == va);
    rh  = ls && (v == rl);
    return {10'(h), 10'(v), disp, hsy, vsy, pen, ls, fs, vbs, rh};
  endfunction

  task automatic check_vec(input string name, input logic [27:0] act, input logic [27:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0d got h=%0d v=%0d flags=%b  expected h=%0d v=%0d flags=%b",
               name, t, act[27:18], act[17:8], act[7:0], exp[27:18], exp[17:8], exp[7:0]);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic string inst_name(input int k);
    return (k == 0) ? "inst_a" : (k == 1) ? "inst_b" : "inst_c";
  endfunction

  // Scoreboard: every rising edge, advance time, then compare #1 later.
  always @(posedge clk) begin
    rl_s = int'(raster_line);
    if (!reset) t = 0;
    else        t++;
    #1;
    for (int k = 0; k < 3; k++) begin
      check_vec(inst_name(k), got[k], model(k, t, rl_s));
      if (phase_fixed && t >= 1) begin
        if (got[k][4]) cnt[k][0]++;
        if (got[k][3]) begin
          if (cnt[k][1] < 2) ls_t[k][cnt[k][1]] = t;
          cnt[k][1]++;
        end
        if (got[k][2]) begin
          if (cnt[k][2] < 2) fs_t[k][cnt[k][2]] = t;
          cnt[k][2]++;
        end
        if (got[k][0]) cnt[k][3]++;
        if (got[k][6] == (k == 1)) cnt[k][4]++;
        if (got[k][5] == (k == 1)) cnt[k][5]++;
        if (got[k][7]) cnt[k][6]++;
        if (got[k][1]) cnt[k][7]++;
      end
      if (phase_ras && got[k][0]) ras_hits[k]++;
    end
  end

  // Async reset values, checked between edges right after assertion.
  task automatic check_reset_now(input string tag);
    check_vec({tag, "_a"}, got[0], {10'd14,  10'd9,   1'b0, 1'b1, 1'b1, 5'b00000});
    check_vec({tag, "_b"}, got[1], {10'd14,  10'd9,   1'b0, 1'b0, 1'b0, 5'b00000});
    check_vec({tag, "_c"}, got[2], {10'd799, 10'd524, 1'b0, 1'b1, 1'b1, 5'b00000});
  endtask

  task automatic pulse_reset();
    #($urandom_range(1, 3));
    reset = 1'b0;
    #1;
    check_reset_now("async_rst");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      ras_hits[k] = 0;
      for (int j = 0; j < 8; j++) cnt[k][j] = 0;
      for (int j = 0; j < 2; j++) begin fs_t[k][j] = -1; ls_t[k][j] = -1; end
    end
    raster_line = 10'd4;
    reset = 1'b1;
    #1 reset = 1'b0;
    #1 check_reset_now("init_rst");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    phase_fixed = 1'b1;

    // Fixed window t=1..900 with raster_line=4.
    repeat (900) @(negedge clk);
    phase_fixed = 1'b0;
    repeat (30) @(negedge clk);
    raster_line = 10'd12;  // beyond the small frames' 10 lines
    phase_ras = 1'b1;
    repeat (570) @(negedge clk);
    phase_ras = 1'b0;

    check_int("a_first_frame_start", fs_t[0][0], 1);
    check_int("a_frame_period", fs_t[0][1] - fs_t[0][0], 150);
    check_int("a_frame_starts", cnt[0][2], 6);
    check_int("a_line_starts", cnt[0][1], 60);
    check_int("a_raster_hits", cnt[0][3], 6);
    check_int("a_vblank_starts", cnt[0][7], 6);
    check_int("a_hsync_active_clks", cnt[0][4], 180);
    check_int("a_vsync_active_clks", cnt[0][5], 180);
    check_int("a_display_clks", cnt[0][6], 288);
    check_int("a_pixel_en_clks", cnt[0][0], 900);
    check_int("b_first_frame_start", fs_t[1][0], 3);
    check_int("b_frame_period", fs_t[1][1] - fs_t[1][0], 450);
    check_int("b_frame_starts", cnt[1][2], 2);
    check_int("b_pixel_en_clks", cnt[1][0], 300);
    check_int("b_line_starts", cnt[1][1], 20);
    check_int("b_raster_hits", cnt[1][3], 2);
    check_int("b_vblank_starts", cnt[1][7], 2);
    check_int("b_display_clks", cnt[1][6], 288);
    check_int("b_hsync_active_clks", cnt[1][4], 180);
    check_int("b_vsync_active_clks", cnt[1][5], 180);
    check_int("c_first_line_start", ls_t[2][0], 1);
    check_int("c_line_period", ls_t[2][1] - ls_t[2][0], 800);
    check_int("c_frame_starts", cnt[2][2], 1);
    check_int("c_hsync_active_clks", cnt[2][4], 96);
    check_int("c_display_clks", cnt[2][6], 740);
    check_int("c_vsync_active_clks", cnt[2][5], 0);
    check_int("a_hits_out_of_range", ras_hits[0], 0);
    check_int("b_hits_out_of_range", ras_hits[1], 0);

    // Random raster_line changes and mid-frame resets, model-checked each cycle.
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 19) == 0) raster_line = 10'($urandom_range(0, 13));
      if (i == 1500 || i == 4217 || $urandom_range(0, 1999) == 0) pulse_reset();
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
